// File: rtl/md_issue_ctrl.sv
// Initiator side of the XALU Start/Busy/HI/LO handshake for md-class ops.
// Launches ops, stalls the pipeline on conflicts, returns mfhi/mflo data, and runs a watchdog.
module md_issue_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int OPW     = 4
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic           ReqValid,
   input  logic [OPW-1:0] ReqOp,
   input  logic [31:0]    ReqA,
   input  logic [31:0]    ReqB,
   output logic           Stall,
   output logic           RdValid,
   output logic [31:0]    RdData,
   output logic           Err,
   output logic [1:0]     Start,
   output logic [2:0]     XALUOp,
   output logic [31:0]    RD1,
   output logic [31:0]    RD2,
   input  logic           Busy,
   input  logic [31:0]    HI,
   input  logic [31:0]    LO
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);
   localparam logic [OPW-1:0] OP_MTHI = OPW'(4);
   localparam logic [OPW-1:0] OP_MTLO = OPW'(5);
   localparam logic [OPW-1:0] OP_MFHI = OPW'(6);
   localparam logic [OPW-1:0] OP_MFLO = OPW'(7);

   state_t        state_q, state_n;
   logic [1:0]    start_q, start_n;
   logic [2:0]    xop_q, xop_n;
   logic [31:0]   rd1_q, rd1_n;
   logic [31:0]   rd2_q, rd2_n;
   logic          rdv_q, rdv_n;
   logic [31:0]   rdd_q, rdd_n;
   logic          md_q, md_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic          err_q, err_n;

   logic is_md, is_mt, is_mf, is_nop, accept;

   assign is_md  = (ReqOp < OP_MTHI);
   assign is_mt  = (ReqOp == OP_MTHI) || (ReqOp == OP_MTLO);
   assign is_mf  = (ReqOp == OP_MFHI) || (ReqOp == OP_MFLO);
   assign is_nop = !(is_md || is_mt || is_mf);

   // Nothing can be accepted while reset is held, so the stall is masked then too.
   assign Stall  = !Reset && ReqValid && !is_nop && ((state_q != S_IDLE) || Busy);
   assign accept = ReqValid && !Stall && !is_nop;

   always_comb begin
      state_n = state_q;
      start_n = start_q;
      xop_n   = xop_q;
      rd1_n   = rd1_q;
      rd2_n   = rd2_q;
      rdv_n   = 1'b0;
      rdd_n   = rdd_q;
      md_n    = md_q;
      cnt_n   = cnt_q;
      err_n   = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept && (is_md || is_mt)) begin
               start_n = is_md ? 2'd1 : 2'd2;
               xop_n   = ReqOp[2:0];
               rd1_n   = ReqA;
               rd2_n   = ReqB;
               md_n    = is_md;
               state_n = S_LAUNCH;
            end else if (accept && is_mf) begin
               rdv_n = 1'b1;
               rdd_n = ReqOp[0] ? LO : HI;
            end else if (Busy) begin
               state_n = S_WAIT;
            end
         end
         S_LAUNCH: begin
            start_n = 2'd0;
            rd1_n   = 32'd0;
            rd2_n   = 32'd0;
            state_n = md_q ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            if (Busy) begin
               // Saturate so a hung unit cannot wrap the counter back below the limit.
               cnt_n = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
               if (cnt_n == CNT_MAX) begin
                  err_n = 1'b1;
               end
            end else begin
               cnt_n   = '0;
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         start_q <= 2'd0;
         xop_q   <= 3'd0;
         rd1_q   <= 32'd0;
         rd2_q   <= 32'd0;
         rdv_q   <= 1'b0;
         rdd_q   <= 32'd0;
         md_q    <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         start_q <= start_n;
         xop_q   <= xop_n;
         rd1_q   <= rd1_n;
         rd2_q   <= rd2_n;
         rdv_q   <= rdv_n;
         rdd_q   <= rdd_n;
         md_q    <= md_n;
         cnt_q   <= cnt_n;
         err_q   <= err_n;
      end
   end

   assign Start   = start_q;
   assign XALUOp  = xop_q;
   assign RD1     = rd1_q;
   assign RD2     = rd2_q;
   assign RdValid = rdv_q;
   assign RdData  = rdd_q;
   assign Err     = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: cycle-by-cycle vector table plus a watchdog sequence.
// Inputs change on the falling edge; outputs are sampled 1ns later within the same cycle.
module tb_md_issue_ctrl;

   logic        Clock;
   logic        Reset;
   logic        ReqValid;
   logic [3:0]  ReqOp;
   logic [31:0] ReqA, ReqB;
   logic        Stall, RdValid, Err;
   logic [31:0] RdData;
   logic [1:0]  Start;
   logic [2:0]  XALUOp;
   logic [31:0] RD1, RD2;
   logic        Busy;
   logic [31:0] HI, LO;

   int checks = 0;
   int errors = 0;

   md_issue_ctrl #(.TIMEOUT(16), .OPW(4)) dut (
      .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqOp(ReqOp),
      .ReqA(ReqA), .ReqB(ReqB), .Stall(Stall), .RdValid(RdValid),
      .RdData(RdData), .Err(Err), .Start(Start), .XALUOp(XALUOp),
      .RD1(RD1), .RD2(RD2), .Busy(Busy), .HI(HI), .LO(LO)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic        rst;
      logic        rv;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        busy;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        stall;
      logic [1:0]  start;
      logic [2:0]  xop;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        rdv;
      logic [31:0] rdd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic rv, logic [3:0] op, logic [31:0] a,
                               logic [31:0] b, logic busy, logic [31:0] hi, logic [31:0] lo,
                               logic stall, logic [1:0] start, logic [2:0] xop,
                               logic [31:0] rd1, logic [31:0] rd2, logic rdv, logic [31:0] rdd);
      vec_t v;
      v.rst = rst; v.rv = rv; v.op = op; v.a = a; v.b = b; v.busy = busy;
      v.hi = hi; v.lo = lo; v.stall = stall; v.start = start; v.xop = xop;
      v.rd1 = rd1; v.rd2 = rd2; v.rdv = rdv; v.rdd = rdd;
      return v;
   endfunction

   task automatic drive(logic rst, logic rv, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                        logic busy, logic [31:0] hi, logic [31:0] lo);
      Reset = rst; ReqValid = rv; ReqOp = op; ReqA = a; ReqB = b;
      Busy = busy; HI = hi; LO = lo;
   endtask

   task automatic check(string name, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   initial begin
      // Reset held, pipeline already presenting a mult.
      vecs.push_back(mk(1,1,0,0,0,0,0,0,                          0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,0,0,                          0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,0,0,                          0,0,0,0,0,0,0));
      // mult -1 * 2, mfhi held through launch and busy, then mflo.
      vecs.push_back(mk(0,1,0,32'hFFFFFFFF,2,0,0,0,               0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,6,0,0,0,0,0,                          1,1,0,32'hFFFFFFFF,2,0,0));
      vecs.push_back(mk(0,1,6,0,0,1,0,0,                          1,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,6,0,0,1,0,0,                          1,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,6,0,0,0,32'hFFFFFFFF,32'hFFFFFFFE,    1,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,6,0,0,0,32'hFFFFFFFF,32'hFFFFFFFE,    0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,7,0,0,0,32'hFFFFFFFF,32'hFFFFFFFE,    0,0,0,0,0,1,32'hFFFFFFFF));
      vecs.push_back(mk(0,0,0,0,0,0,32'hFFFFFFFF,32'hFFFFFFFE,    0,0,0,0,0,1,32'hFFFFFFFE));
      // div 7 / -2 then mflo, mfhi.
      vecs.push_back(mk(0,1,2,7,32'hFFFFFFFE,0,32'hFFFFFFFF,32'hFFFFFFFE, 0,0,0,0,0,0,32'hFFFFFFFE));
      vecs.push_back(mk(0,1,7,0,0,0,32'hFFFFFFFF,32'hFFFFFFFE,    1,1,2,7,32'hFFFFFFFE,0,32'hFFFFFFFE));
      vecs.push_back(mk(0,1,7,0,0,1,32'hFFFFFFFF,32'hFFFFFFFE,    1,0,2,0,0,0,32'hFFFFFFFE));
      vecs.push_back(mk(0,1,7,0,0,0,1,32'hFFFFFFFD,               1,0,2,0,0,0,32'hFFFFFFFE));
      vecs.push_back(mk(0,1,7,0,0,0,1,32'hFFFFFFFD,               0,0,2,0,0,0,32'hFFFFFFFE));
      vecs.push_back(mk(0,1,6,0,0,0,1,32'hFFFFFFFD,               0,0,2,0,0,1,32'hFFFFFFFD));
      // divu 7 / 0xFFFFFFFE then mflo, mfhi.
      vecs.push_back(mk(0,1,3,7,32'hFFFFFFFE,0,1,32'hFFFFFFFD,    0,0,2,0,0,1,1));
      vecs.push_back(mk(0,1,7,0,0,0,1,32'hFFFFFFFD,               1,1,3,7,32'hFFFFFFFE,0,1));
      vecs.push_back(mk(0,1,7,0,0,1,1,32'hFFFFFFFD,               1,0,3,0,0,0,1));
      vecs.push_back(mk(0,1,7,0,0,0,7,0,                          1,0,3,0,0,0,1));
      vecs.push_back(mk(0,1,7,0,0,0,7,0,                          0,0,3,0,0,0,1));
      vecs.push_back(mk(0,1,6,0,0,0,7,0,                          0,0,3,0,0,1,0));
      // mthi immediately followed by mfhi: one stall cycle in LAUNCH.
      vecs.push_back(mk(0,1,4,32'h12345678,0,0,7,0,               0,0,3,0,0,1,7));
      vecs.push_back(mk(0,1,6,0,0,0,7,0,                          1,2,4,32'h12345678,0,0,7));
      vecs.push_back(mk(0,1,6,0,0,0,32'h12345678,0,               0,0,4,0,0,0,7));
      // mult then div back to back; div waits for Busy to fall.
      vecs.push_back(mk(0,1,0,3,5,0,32'h12345678,0,               0,0,4,0,0,1,32'h12345678));
      vecs.push_back(mk(0,1,2,32'h64,7,0,32'h12345678,0,          1,1,0,3,5,0,32'h12345678));
      vecs.push_back(mk(0,1,2,32'h64,7,1,32'h12345678,0,          1,0,0,0,0,0,32'h12345678));
      vecs.push_back(mk(0,1,2,32'h64,7,1,32'h12345678,0,          1,0,0,0,0,0,32'h12345678));
      vecs.push_back(mk(0,1,2,32'h64,7,0,32'h12345678,0,          1,0,0,0,0,0,32'h12345678));
      vecs.push_back(mk(0,1,2,32'h64,7,0,32'h12345678,0,          0,0,0,0,0,0,32'h12345678));
      vecs.push_back(mk(0,0,0,0,0,0,32'h12345678,0,               0,1,2,32'h64,7,0,32'h12345678));
      vecs.push_back(mk(0,0,0,0,0,1,32'h12345678,0,               0,0,2,0,0,0,32'h12345678));
      // Reset mid-div, then an mflo is accepted right away.
      vecs.push_back(mk(1,1,7,0,0,1,32'h12345678,0,               0,0,2,0,0,0,32'h12345678));
      vecs.push_back(mk(0,1,7,0,0,0,0,32'hA5A5A5A5,               0,0,0,0,0,0,0));
      // NOP never stalls; unexpected Busy in IDLE stalls and moves to WAIT.
      vecs.push_back(mk(0,1,9,0,0,0,0,32'hA5A5A5A5,               0,0,0,0,0,1,32'hA5A5A5A5));
      vecs.push_back(mk(0,1,6,0,0,1,0,32'hA5A5A5A5,               1,0,0,0,0,0,32'hA5A5A5A5));
      vecs.push_back(mk(0,1,6,0,0,1,0,32'hA5A5A5A5,               1,0,0,0,0,0,32'hA5A5A5A5));
      vecs.push_back(mk(0,1,6,0,0,0,0,32'hA5A5A5A5,               1,0,0,0,0,0,32'hA5A5A5A5));
      vecs.push_back(mk(0,1,9,0,0,0,0,32'hA5A5A5A5,               0,0,0,0,0,0,32'hA5A5A5A5));

      drive(1,1,0,0,0,0,0,0);
      @(negedge Clock);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].rv, vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].busy, vecs[i].hi, vecs[i].lo);
         #1;
         check($sformatf("vec%0d{stall,start,xop,rd1,rd2,rdv,rdd,err}", i),
               128'({Stall, Start, XALUOp, RD1, RD2, RdValid, RdData, Err}),
               128'({vecs[i].stall, vecs[i].start, vecs[i].xop, vecs[i].rd1, vecs[i].rd2,
                     vecs[i].rdv, vecs[i].rdd, 1'b0}));
         @(negedge Clock);
      end

      // Watchdog: multu launched, then the XALU never drops Busy.
      drive(0,1,1,1,1,0,0,0);
      #1;
      check("wd_accept_stall", 128'(Stall), 128'(0));
      @(negedge Clock);
      drive(0,0,0,0,0,0,0,0);
      #1;
      check("wd_launch{start,xop}", 128'({Start, XALUOp}), 128'({2'd1, 3'd1}));
      @(negedge Clock);
      for (int k = 1; k <= 16; k++) begin
         drive(0,1,0,0,0,1,0,0);
         #1;
         check($sformatf("wd_wait%0d{err,stall,start}", k),
               128'({Err, Stall, Start}), 128'({1'b0, 1'b1, 2'd0}));
         @(negedge Clock);
      end
      for (int k = 17; k <= 26; k++) begin
         drive(0,1,9,0,0,1,0,0);
         #1;
         check($sformatf("wd_wait%0d{err,stall,start}", k),
               128'({Err, Stall, Start}), 128'({1'b1, 1'b0, 2'd0}));
         @(negedge Clock);
      end
      drive(1,0,0,0,0,1,0,0);
      #1;
      check("wd_err_before_reset", 128'(Err), 128'(1));
      @(negedge Clock);
      drive(0,0,0,0,0,0,0,0);
      #1;
      check("wd_after_reset{err,stall,start}", 128'({Err, Stall, Start}), 128'(0));
      @(negedge Clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- E-stage front end for the multiply/divide unit; it is the initiator side of the XALU Start/Busy/HI/LO interface.
- Accepts decoded md-class requests from the pipeline (mult, multu, div, divu, mthi, mtlo, mfhi, mflo).
- Launches them on the XALU with a one-cycle Start pulse and tracks the operation through launch and Busy.
- Stalls the pipeline on structural and RAW conflicts, returns mfhi/mflo data, and flags a hung unit via a watchdog.

Parameters:
- TIMEOUT, 16: max cycles in WAIT before Err sets.
- OPW, 4: width of ReqOp.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  1  pipeline presents a request this cycle.
- ReqOp  in  OPW  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo, others no-op.
- ReqA  in  32  rs operand.
- ReqB  in  32  rt operand.
- Stall  out  1  combinational; pipeline must hold the request.
- RdValid  out  1  registered; RdData is valid.
- RdData  out  32  registered HI or LO for mfhi/mflo.
- Err  out  1  sticky watchdog flag.
- Start  out  2  to XALU: 1 launches mul/div, 2 launches mthi/mtlo, 0 idle.
- XALUOp  out  3  to XALU: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo.
- RD1  out  32  to XALU: operand A.
- RD2  out  32  to XALU: operand B.
- Busy  in  1  from XALU.
- HI  in  32  from XALU.
- LO  in  32  from XALU.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; Start=0, XALUOp=0, RD1=RD2=0; RdValid=0, RdData=0; Err=0; watchdog counter=0.
- Reset mid-operation: forces IDLE and drops Start in the same edge. No request is replayed.
- Op classes: MD = 0..3; MT = 4,5; MF = 6,7; NOP = 8..15.
- Stall = ReqValid && class in {MD, MT, MF} && (state != IDLE || Busy). NOP never stalls.
- Accept = ReqValid && !Stall && class != NOP.
- States:
  - IDLE:
    - Accept of MD or MT in cycle N: drive Start (1 for MD, 2 for MT), XALUOp=ReqOp[2:0], RD1=ReqA, RD2=ReqB as registered outputs during N+1; go to LAUNCH.
    - Accept of MF in cycle N: RdValid=1 in N+1, with RdData = HI (op 6) or LO (op 7) sampled at the N edge. State stays IDLE.
  - LAUNCH (exactly 1 cycle; Start asserted):
    - Next state: MD -> WAIT; MT -> IDLE.
    - Start, RD1 and RD2 return to 0 at the exit edge.
  - WAIT:
    - Stays while Busy=1. Counter increments each WAIT cycle.
    - Busy=0 -> IDLE, counter cleared.
    - Counter reaching TIMEOUT: Err<=1 (sticky until Reset); state stays WAIT.
- Start is a single-cycle pulse; a request is never relaunched while Busy=1.
- RdValid is a single-cycle pulse per accepted MF.
- A request arriving in the last Busy=1 cycle stalls; it is accepted the following cycle, so the first post-result cycle sees updated HI/LO.
- Busy=1 while in IDLE (unexpected): stall applies; state moves to WAIT.
- RD1/RD2 pass operands unmodified; signedness is selected by XALUOp only.

Test Plan:
- Reset held 3 cycles with ReqValid=1, ReqOp=0 -> every output 0 throughout; Stall=0 in cycle after release only when Busy=0.
- mult A=0xFFFFFFFF, B=2, then mfhi/mflo held valid:
  - Start=1/XALUOp=0 for exactly one cycle.
  - Stall high through LAUNCH and all Busy cycles.
  - Then RdData=0xFFFFFFFF (HI), then 0xFFFFFFFE (LO), one RdValid pulse each.
- div A=7, B=0xFFFFFFFE, then mflo/mfhi -> LO=0xFFFFFFFD, HI=0x00000001; divu with same operands -> LO=0, HI=7.
- mthi A=0x12345678 immediately followed by mfhi -> mfhi stalls exactly 1 cycle (LAUNCH); RdData=0x12345678; Start=2 seen once.
- Back-to-back mult then div:
  - div stalls until Busy falls; its Start pulse comes the cycle after acceptance.
  - No Start while Busy=1.
  - Reset asserted mid-div -> IDLE, Stall=0, Start=0 next cycle.
- Stub XALU holding Busy=1 forever -> Err rises after TIMEOUT (16) WAIT cycles and stays 1 until Reset; ReqOp=9 with ReqValid -> Stall=0, no Start.
